// File: rtl/l2_cache_control_mwb_pkg.sv
// Shared types for the L2 cache controller: FSM state encoding, width helpers
// and the bundle of one-bit datapath/memory control strobes.
package l2_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EVICT   = 3'd1,
    FILL    = 3'd2,
    RESPOND = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  function automatic int way_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Way selects stay outside the struct because their width is a module parameter.
  typedef struct packed {
    logic mem_resp;
    logic tag_sel;
    logic source_sel;
    logic load_cache;
    logic load_lru;
    logic load_dirty_arr;
    logic ewb_push;
    logic ewb_pop;
    logic evict_addr_sel;
    logic read_from_mem;
    logic write_to_mem;
  } ctrl_t;

endpackage

// File: rtl/l2_ewb_counter.sv
// Occupancy counter for the eviction write buffer with full/empty flags.
// Push-when-full and pop-when-empty are flagged and ignored.
module l2_ewb_counter
  import l2_ctrl_pkg::*;
#(
  parameter int EWB_DEPTH = 4,
  localparam int CNT_W = cnt_w(EWB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] count_q, count_d;

  assign full_o  = (count_q == CNT_W'(EWB_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i && !full_o) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && !push_i && !empty_o) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
      assert (!(push_i && full_o)) else $error("ewb counter overflow");
      assert (!(pop_i && empty_o)) else $error("ewb counter underflow");
    end
  end

endmodule

// File: rtl/l2_cache_control_mwb.sv
// L2 cache controller FSM with an eviction write buffer: dirty victims are
// pushed to the EWB so fills go first; the EWB drains when idle, full or hit by a miss.
module l2_cache_control_mwb
  import l2_ctrl_pkg::*;
#(
  parameter int NUM_WAYS  = 8,
  parameter int EWB_DEPTH = 4,
  localparam int WAY_W = way_w(NUM_WAYS),
  localparam int CNT_W = cnt_w(EWB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic             cache_hit,
  input  logic             dirty_o,
  input  logic [WAY_W-1:0] hit_idx,
  input  logic [WAY_W-1:0] plru_idx,
  input  logic             ewb_match,
  output logic [WAY_W-1:0] way_sel,
  output logic             tag_sel,
  output logic             source_sel,
  output logic             load_cache,
  output logic             load_lru,
  output logic             load_dirty_arr,
  output logic [WAY_W-1:0] dirty_sel,
  output logic             read_cache_data,
  output logic             ewb_push,
  output logic             ewb_pop,
  output logic             evict_addr_sel,
  output logic [CNT_W-1:0] ewb_count,
  output logic             ewb_full,
  output logic             ewb_empty,
  input  logic             resp_from_mem,
  output logic             read_from_mem,
  output logic             write_to_mem,
  output logic [2:0]       state_o
);

  // Handshakes: mem_read/mem_write are held until the one-cycle mem_resp;
  // read_from_mem/write_to_mem are held until the cycle resp_from_mem is high.

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic [WAY_W-1:0] way_sel_c, dirty_sel_c;
  logic             req;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ctrl         = '0;
    ctrl.tag_sel = 1'b1;
    way_sel_c    = hit_idx;
    dirty_sel_c  = plru_idx;
    case (state_q)
      IDLE: begin
        // A miss on a line still sitting in the EWB must drain first (RAW hazard).
        if (req && cache_hit)                 state_d = RESPOND;
        else if (req && ewb_match)            state_d = DRAIN;
        else if (req && dirty_o && ewb_full)  state_d = DRAIN;
        else if (req && dirty_o)              state_d = EVICT;
        else if (req)                         state_d = FILL;
        else if (!ewb_empty)                  state_d = DRAIN;
      end
      EVICT: begin
        way_sel_c     = plru_idx;
        ctrl.tag_sel  = 1'b0;
        ctrl.ewb_push = 1'b1;
        state_d       = FILL;
      end
      FILL: begin
        ctrl.read_from_mem = 1'b1;
        way_sel_c          = plru_idx;
        if (resp_from_mem) begin
          ctrl.load_cache     = 1'b1;
          ctrl.source_sel     = 1'b1;
          ctrl.load_dirty_arr = 1'b1;
          state_d             = RESPOND;
        end
      end
      RESPOND: begin
        ctrl.mem_resp = 1'b1;
        ctrl.load_lru = 1'b1;
        if (mem_write) begin
          ctrl.load_cache     = 1'b1;
          ctrl.load_dirty_arr = 1'b1;
          dirty_sel_c         = hit_idx;
        end
        state_d = IDLE;
      end
      DRAIN: begin
        // Runs to completion regardless of new CPU requests.
        ctrl.write_to_mem   = 1'b1;
        ctrl.evict_addr_sel = 1'b1;
        if (resp_from_mem) begin
          ctrl.ewb_pop = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  l2_ewb_counter #(
    .EWB_DEPTH (EWB_DEPTH)
  ) u_ewb_counter (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ctrl.ewb_push),
    .pop_i   (ctrl.ewb_pop),
    .count_o (ewb_count),
    .full_o  (ewb_full),
    .empty_o (ewb_empty)
  );

  assign mem_resp        = ctrl.mem_resp;
  assign way_sel         = way_sel_c;
  assign tag_sel         = ctrl.tag_sel;
  assign source_sel      = ctrl.source_sel;
  assign load_cache      = ctrl.load_cache;
  assign load_lru        = ctrl.load_lru;
  assign load_dirty_arr  = ctrl.load_dirty_arr;
  assign dirty_sel       = dirty_sel_c;
  assign read_cache_data = 1'b1;
  assign ewb_push        = ctrl.ewb_push;
  assign ewb_pop         = ctrl.ewb_pop;
  assign evict_addr_sel  = ctrl.evict_addr_sel;
  assign read_from_mem   = ctrl.read_from_mem;
  assign write_to_mem    = ctrl.write_to_mem;
  assign state_o         = state_q;

endmodule

// File: tb/tb_l2_cache_control_mwb.sv
// Directed bench for l2_cache_control_mwb: hits, clean/dirty misses, EWB fill,
// RAW-match drains, opportunistic drains and reset mid-transaction.
module tb_l2_cache_control_mwb;
  import l2_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read, mem_write, mem_resp;
  logic       cache_hit, dirty_o, ewb_match;
  logic [2:0] hit_idx, plru_idx, way_sel, dirty_sel;
  logic       tag_sel, source_sel, load_cache, load_lru, load_dirty_arr;
  logic       read_cache_data, ewb_push, ewb_pop, evict_addr_sel;
  logic [2:0] ewb_count;
  logic       ewb_full, ewb_empty;
  logic       resp_from_mem, read_from_mem, write_to_mem;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  l2_cache_control_mwb #(.NUM_WAYS(8), .EWB_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .cache_hit(cache_hit), .dirty_o(dirty_o),
    .hit_idx(hit_idx), .plru_idx(plru_idx), .ewb_match(ewb_match),
    .way_sel(way_sel), .tag_sel(tag_sel), .source_sel(source_sel),
    .load_cache(load_cache), .load_lru(load_lru), .load_dirty_arr(load_dirty_arr),
    .dirty_sel(dirty_sel), .read_cache_data(read_cache_data),
    .ewb_push(ewb_push), .ewb_pop(ewb_pop), .evict_addr_sel(evict_addr_sel),
    .ewb_count(ewb_count), .ewb_full(ewb_full), .ewb_empty(ewb_empty),
    .resp_from_mem(resp_from_mem), .read_from_mem(read_from_mem),
    .write_to_mem(write_to_mem), .state_o(state_o)
  );

  wire [9:0] strobes = {mem_resp, load_cache, load_lru, load_dirty_arr, ewb_push,
                        ewb_pop, evict_addr_sel, read_from_mem, write_to_mem, source_sel};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One memory transaction of lat cycles; resp_from_mem rises on the last one.
  task automatic mem_phase(input int lat, input bit is_fill, input logic [2:0] way);
    for (int i = 1; i <= lat; i++) begin
      resp_from_mem = (i == lat);
      #1;
      chk("count_in_mem", ewb_count, exp_cnt);
      if (is_fill) begin
        chk("fill_state", state_o, FILL);
        chk("fill_rd", read_from_mem, 1);
        chk("fill_wr", write_to_mem, 0);
        chk("fill_way", way_sel, way);
        chk("fill_load", load_cache, (i == lat));
        chk("fill_src", source_sel, (i == lat));
        chk("fill_ldirty", load_dirty_arr, (i == lat));
      end else begin
        chk("drain_state", state_o, DRAIN);
        chk("drain_wr", write_to_mem, 1);
        chk("drain_rd", read_from_mem, 0);
        chk("drain_esel", evict_addr_sel, 1);
        chk("drain_pop", ewb_pop, (i == lat));
      end
      if (i < lat) tick();
    end
    tick();
    resp_from_mem = 1'b0;
  endtask

  // RESPOND cycle after a fill: datapath now reports a hit on the filled way.
  task automatic respond_chk(input logic [2:0] way, input bit wr);
    cache_hit = 1'b1;
    hit_idx   = way;
    plru_idx  = 3'(way + 3'd1);
    #1;
    chk("rsp_state", state_o, RESPOND);
    chk("rsp_resp", mem_resp, 1);
    chk("rsp_lru", load_lru, 1);
    chk("rsp_way", way_sel, way);
    chk("rsp_load", load_cache, wr);
    chk("rsp_dsel", dirty_sel, wr ? way : 3'(way + 3'd1));
    chk("rsp_mem", {read_from_mem, write_to_mem}, 0);
  endtask

  // Called in an IDLE cycle; returns in the RESPOND cycle with the request still held.
  task automatic fill_miss(input logic [2:0] way, input int lat, input bit wr);
    mem_read = !wr; mem_write = wr; cache_hit = 0; dirty_o = 0; ewb_match = 0;
    plru_idx = way; hit_idx = 3'(way + 3'd3);
    #1;
    chk("miss_idle", state_o, IDLE);
    tick();
    mem_phase(lat, 1, way);
    respond_chk(way, wr);
  endtask

  task automatic dirty_miss(input logic [2:0] way, input int lat, input bit wr);
    mem_read = !wr; mem_write = wr; cache_hit = 0; dirty_o = 1; ewb_match = 0;
    plru_idx = way; hit_idx = 3'(way + 3'd3);
    #1;
    chk("dmiss_idle", state_o, IDLE);
    tick();
    #1;
    chk("evict_state", state_o, EVICT);
    chk("evict_push", ewb_push, 1);
    chk("evict_tag", tag_sel, 0);
    chk("evict_way", way_sel, way);
    tick();
    exp_cnt++;
    mem_phase(lat, 1, way);
    respond_chk(way, wr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; cache_hit = 0; dirty_o = 0;
    ewb_match = 0; hit_idx = 0; plru_idx = 0; resp_from_mem = 0;
    tick(); tick();
    #1;
    chk("rst_state", state_o, IDLE);
    chk("rst_count", ewb_count, 0);
    chk("rst_empty", ewb_empty, 1);
    chk("rst_full", ewb_full, 0);
    chk("rst_strobes", strobes, 0);
    chk("rst_rcd", read_cache_data, 1);
    chk("rst_tag", tag_sel, 1);
    rst = 0;
    tick();

    // read hit on way 5
    mem_read = 1; cache_hit = 1; hit_idx = 5; plru_idx = 1;
    #1;
    chk("hit_idle_resp", mem_resp, 0);
    tick();
    #1;
    chk("hit_state", state_o, RESPOND);
    chk("hit_resp", mem_resp, 1);
    chk("hit_lru", load_lru, 1);
    chk("hit_way", way_sel, 5);
    chk("hit_mem", {read_from_mem, write_to_mem}, 0);
    chk("hit_load", load_cache, 0);
    mem_read = 0; cache_hit = 0;
    tick();
    #1;
    chk("hit_back_idle", state_o, IDLE);
    chk("hit_back_strobes", strobes, 0);

    // clean read miss, 10-cycle memory
    fill_miss(2, 10, 0);
    mem_read = 0; cache_hit = 0;
    tick();
    #1;
    chk("clean_idle", state_o, IDLE);
    chk("clean_strobes", strobes, 0);

    // four back-to-back dirty misses fill the EWB
    dirty_miss(1, 3, 0); tick();
    dirty_miss(3, 2, 1); tick();
    dirty_miss(6, 3, 0); tick();
    dirty_miss(7, 2, 1);
    chk("ewb4_count", ewb_count, 4);
    chk("ewb4_full", ewb_full, 1);
    tick();

    // fifth dirty miss drains first
    mem_read = 1; mem_write = 0; cache_hit = 0; dirty_o = 1; plru_idx = 4;
    #1;
    chk("full_idle", state_o, IDLE);
    tick();
    mem_phase(4, 0, 0);
    exp_cnt--;
    #1;
    chk("full_after_drain", ewb_count, 3);
    chk("full_after_flag", ewb_full, 0);
    dirty_miss(4, 2, 0);
    chk("ewb_refull", ewb_count, 4);
    mem_read = 0; cache_hit = 0; dirty_o = 0;
    tick();
    tick();
    mem_phase(2, 0, 0);
    exp_cnt--;

    // miss with ewb_match held for two drains (3 -> 1)
    mem_read = 1; cache_hit = 0; dirty_o = 0; ewb_match = 1; plru_idx = 0;
    #1;
    chk("match_idle", state_o, IDLE);
    chk("match_cnt", ewb_count, 3);
    tick();
    mem_phase(3, 0, 0);
    exp_cnt--;
    #1;
    chk("match_idle2", state_o, IDLE);
    chk("match_no_rd", read_from_mem, 0);
    tick();
    mem_phase(2, 0, 0);
    exp_cnt--;
    #1;
    chk("match_cnt1", ewb_count, 1);
    fill_miss(0, 3, 0);
    tick();

    // push one more (count 2), then idle: two opportunistic drains
    dirty_miss(6, 2, 1);
    chk("opp_cnt2", ewb_count, 2);
    mem_write = 0; mem_read = 0; cache_hit = 0; dirty_o = 0;
    tick();
    #1;
    chk("opp_idle", state_o, IDLE);
    tick();
    mem_read = 1; cache_hit = 1; hit_idx = 3;
    mem_phase(4, 0, 0);
    exp_cnt--;
    #1;
    chk("middrain_idle", state_o, IDLE);
    chk("middrain_resp0", mem_resp, 0);
    tick();
    #1;
    chk("middrain_state", state_o, RESPOND);
    chk("middrain_resp", mem_resp, 1);
    chk("middrain_way", way_sel, 3);
    mem_read = 0; cache_hit = 0;
    tick();
    tick();
    mem_phase(3, 0, 0);
    exp_cnt--;
    #1;
    chk("opp_empty", ewb_empty, 1);
    chk("opp_count0", ewb_count, 0);
    tick();
    #1;
    chk("opp_stay_idle", state_o, IDLE);
    chk("opp_strobes", strobes, 0);

    // reset during FILL
    mem_read = 1; cache_hit = 0; dirty_o = 0; plru_idx = 1;
    tick();
    #1;
    chk("rf_rd", read_from_mem, 1);
    tick();
    rst = 1;
    tick();
    #1;
    chk("rf_state", state_o, IDLE);
    chk("rf_count", ewb_count, 0);
    chk("rf_strobes", strobes, 0);
    mem_read = 0; rst = 0;
    tick();

    // reset during DRAIN
    dirty_miss(5, 2, 0);
    mem_read = 0; cache_hit = 0; dirty_o = 0;
    tick();
    tick();
    #1;
    chk("rd_wr", write_to_mem, 1);
    chk("rd_cnt1", ewb_count, 1);
    rst = 1;
    tick();
    #1;
    exp_cnt = 0;
    chk("rd_state", state_o, IDLE);
    chk("rd_count", ewb_count, 0);
    chk("rd_empty", ewb_empty, 1);
    chk("rd_strobes", strobes, 0);
    rst = 0;
    tick();
    #1;
    chk("rd_post_idle", state_o, IDLE);
    chk("rd_post_strobes", strobes, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
